alu_sram_seq: RTL and testbench
===============================

Name: alu_sram_seq

Overview:
- Sequencer that drives the combinational ALU over a block of operand pairs held in the single-port 1rw SRAM (8x512 class).
- Accepts one command (op, source base, destination base, length) over a valid/ready handshake.
- For each element, reads operands A and B from SRAM, drives the ALU, and writes the result back to SRAM.
- Sits between a host/testbench command source and the shared `alu` + `sram_8x512_1rw` pair. It is the only master of both.

Parameters:
- width_p, 8, data width of ALU operands, result, SRAM word and write mask
- addr_width_p, 9, SRAM address width (width_p+1 for the 512-deep macro)
- len_width_p, 8, width of the element-count field

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- cmd_v_i  in  1  command valid
- cmd_ready_o  out  1  command ready; high only in IDLE
- cmd_op_i  in  2  ALU select for the whole block
- cmd_src_i  in  addr_width_p  source base; element k reads src+2k (A) and src+2k+1 (B)
- cmd_dst_i  in  addr_width_p  destination base; element k writes dst+k
- cmd_len_i  in  len_width_p  number of elements (0 allowed)
- abort_i  in  1  request early stop, honoured at an element boundary
- busy_o  out  1  high from accept until DONE inclusive
- done_o  out  1  one-cycle pulse on completion or abort
- aborted_o  out  1  valid with done_o; 1 if the block was cut short by abort
- elems_done_o  out  len_width_p  elements written since last accept
- alu_sel_o  out  2  to ALU sel_i
- alu_a_o  out  width_p  to ALU a_i
- alu_b_o  out  width_p  to ALU b_i
- alu_res_i  in  width_p  from ALU res_o
- sram_ce_o  out  1  SRAM chip enable
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  addr_width_p  SRAM address
- sram_wd_o  out  width_p  SRAM write data
- sram_wmask_o  out  width_p  SRAM write mask; constant all-ones
- sram_rd_i  in  width_p  SRAM read data; valid one cycle after a read-enable edge

Behaviour:
- Reset:
  - Asserting reset_n_i=0 immediately forces the FSM to IDLE.
  - All outputs go to 0, except cmd_ready_o=1 and sram_wmask_o=all-ones.
  - Internal registers are cleared: a_r, b_r, k, op_r, src_r, dst_r, len_r, abort_pend.
  - Reset mid-operation aborts silently: no done_o, no further SRAM access. SRAM contents already written stay as written.
- Command acceptance: on a clock edge with cmd_v_i & cmd_ready_o, latch op/src/dst/len, clear k, elems_done_o and abort_pend, then go to RD_A. If len=0, go to DONE instead.
- While busy:
  - cmd_ready_o=0; cmd_v_i is ignored.
  - alu_sel_o=op_r, alu_a_o=a_r, alu_b_o=b_r, all held stable.
- States, one cycle each:
  - RD_A: ce=1, we=0, addr=src_r+2k.
  - RD_B: ce=1, we=0, addr=src_r+2k+1; a_r<=sram_rd_i.
  - CAP: ce=0; b_r<=sram_rd_i.
  - WR: ce=1, we=1, addr=dst_r+k, wd=alu_res_i; elems_done_o<=k+1.
    - If k+1==len_r or abort_pend: go to DONE.
    - Otherwise: k<=k+1, go to RD_A.
  - DONE: done_o=1, aborted_o=abort_pend, busy_o=1; next state IDLE.
- Addresses are computed modulo 2^addr_width_p (wrap-around, no error).
- Throughput and latency: 4 cycles per element. With accept at edge 0:
  - First write occurs in the cycle after edge 3.
  - done_o is high in the cycle after edge 4N.
  - For len=0, done_o is high in the cycle after edge 0 with no SRAM access.
- abort_i:
  - Sampled every busy cycle and sets a sticky abort_pend.
  - The element in progress always completes its write.
  - Abort asserted in IDLE or in DONE has no effect.
- ce=0 in IDLE and DONE; SRAM outputs are don't-care-free (driven 0) whenever ce=0.

Test Plan:
Bench ALU stub: 00 add, 01 sub, 10 and, 11 or.
- mem[0]=1, mem[1]=3; cmd op=00, src=0, dst=16, len=1 → write mem[16]=4 in cycle 4; done_o in cycle 5; aborted_o=0; elems_done_o=1.
- mem[0..5]=5,2,9,4,7,7; op=01, src=0, dst=100, len=3 → mem[100..102]=3,5,0; 12 data cycles; SRAM address sequence 0,1,-,100,2,3,-,101,4,5,-,102.
- src=510, dst=511, len=2, op=11 → reads 510, 511, 0, 1; writes 511 then 0.
- len=0 → done_o the cycle after accept; sram_ce_o never asserts.
- len=5; abort_i pulsed during element 1's RD_B → writes for elements 0 and 1 only; done_o with aborted_o=1; elems_done_o=2.
- cmd_v_i held during busy → ignored; second command accepted the cycle after DONE.
- reset_n_i=0 during WR of element 2 → all outputs 0 asynchronously; cmd_ready_o=1; no done_o.

Source files
------------

// File: rtl/alu_sram_seq.sv
// Block sequencer: streams operand pairs out of the 1rw SRAM through the
// combinational ALU and writes each result back, four cycles per element.
module alu_sram_seq #(
    parameter int width_p      = 8,
    parameter int addr_width_p = 9,
    parameter int len_width_p  = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    cmd_v_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_op_i,
    input  logic [addr_width_p-1:0] cmd_src_i,
    input  logic [addr_width_p-1:0] cmd_dst_i,
    input  logic [len_width_p-1:0]  cmd_len_i,
    input  logic                    abort_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    aborted_o,
    output logic [len_width_p-1:0]  elems_done_o,
    output logic [1:0]              alu_sel_o,
    output logic [width_p-1:0]      alu_a_o,
    output logic [width_p-1:0]      alu_b_o,
    input  logic [width_p-1:0]      alu_res_i,
    output logic                    sram_ce_o,
    output logic                    sram_we_o,
    output logic [addr_width_p-1:0] sram_addr_o,
    output logic [width_p-1:0]      sram_wd_o,
    output logic [width_p-1:0]      sram_wmask_o,
    input  logic [width_p-1:0]      sram_rd_i
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, WR, DONE} state_e;

    state_e                  state, state_n;
    logic [width_p-1:0]      a_r, b_r;
    logic [len_width_p-1:0]  k, k_next, len_r;
    logic [1:0]              op_r;
    logic [addr_width_p-1:0] src_r, dst_r, addr_a;
    logic                    abort_pend, last;

    // Operand A of element k lives at src+2k, B right after it; wraps modulo 2^addr_width_p.
    assign k_next = k + len_width_p'(1);
    assign last   = (k_next == len_r);
    assign addr_a = src_r + addr_width_p'({k, 1'b0});

    assign alu_sel_o    = op_r;
    assign alu_a_o      = a_r;
    assign alu_b_o      = b_r;
    assign sram_wmask_o = '1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n     = state;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        aborted_o   = 1'b0;
        sram_ce_o   = 1'b0;
        sram_we_o   = 1'b0;
        sram_addr_o = '0;
        sram_wd_o   = '0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_v_i) state_n = (cmd_len_i == '0) ? DONE : RD_A;
            end
            RD_A: begin
                sram_ce_o   = 1'b1;
                sram_addr_o = addr_a;
                state_n     = RD_B;
            end
            RD_B: begin
                sram_ce_o   = 1'b1;
                sram_addr_o = addr_a + addr_width_p'(1);
                state_n     = CAP;
            end
            CAP: state_n = WR;
            WR: begin
                sram_ce_o   = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = dst_r + addr_width_p'(k);
                sram_wd_o   = alu_res_i;
                state_n     = (last || abort_pend) ? DONE : RD_A;
            end
            DONE: begin
                done_o    = 1'b1;
                aborted_o = abort_pend;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Abort is only recorded while elements are in flight, so it never leaks into IDLE/DONE.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            a_r          <= '0;
            b_r          <= '0;
            k            <= '0;
            op_r         <= '0;
            src_r        <= '0;
            dst_r        <= '0;
            len_r        <= '0;
            abort_pend   <= 1'b0;
            elems_done_o <= '0;
        end else begin
            if (state == IDLE && cmd_v_i) begin
                op_r         <= cmd_op_i;
                src_r        <= cmd_src_i;
                dst_r        <= cmd_dst_i;
                len_r        <= cmd_len_i;
                k            <= '0;
                elems_done_o <= '0;
                abort_pend   <= 1'b0;
            end
            if (abort_i && (state == RD_A || state == RD_B || state == CAP || state == WR))
                abort_pend <= 1'b1;
            if (state == RD_B) a_r <= sram_rd_i;
            if (state == CAP)  b_r <= sram_rd_i;
            if (state == WR) begin
                elems_done_o <= k_next;
                if (!(last || abort_pend)) k <= k_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_sram_seq.sv
// Directed bench for alu_sram_seq with a behavioural 512x8 SRAM and ALU stub.
module tb_alu_sram_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_v, cmd_ready, abort, busy, done, aborted;
    logic [1:0] cmd_op, alu_sel;
    logic [8:0] cmd_src, cmd_dst, sram_addr;
    logic [7:0] cmd_len, elems_done;
    logic [7:0] alu_a, alu_b, alu_res;
    logic       sram_ce, sram_we;
    logic [7:0] sram_wd, sram_wmask, sram_rd;

    logic [7:0] mem [0:511];
    logic       load_en = 1'b0;
    logic [8:0] load_addr = '0;
    logic [7:0] load_data = '0;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_addr2 [12] = '{9'd0, 9'd1, 9'd0, 9'd100, 9'd2, 9'd3, 9'd0, 9'd101,
                                   9'd4, 9'd5, 9'd0, 9'd102};
    logic [8:0] exp_addr3 [8]  = '{9'd510, 9'd511, 9'd0, 9'd511, 9'd0, 9'd1, 9'd0, 9'd0};
    logic [7:0] exp_wd2 [3]    = '{8'd3, 8'd5, 8'd0};

    always #5 clk = ~clk;

    alu_sram_seq dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len),
        .abort_i(abort), .busy_o(busy), .done_o(done), .aborted_o(aborted),
        .elems_done_o(elems_done), .alu_sel_o(alu_sel), .alu_a_o(alu_a),
        .alu_b_o(alu_b), .alu_res_i(alu_res), .sram_ce_o(sram_ce),
        .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_wd_o(sram_wd),
        .sram_wmask_o(sram_wmask), .sram_rd_i(sram_rd)
    );

    always_comb begin
        case (alu_sel)
            2'b00:   alu_res = alu_a + alu_b;
            2'b01:   alu_res = alu_a - alu_b;
            2'b10:   alu_res = alu_a & alu_b;
            default: alu_res = alu_a | alu_b;
        endcase
    end

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (sram_ce) begin
            if (sram_we) mem[sram_addr] <= (sram_wd & sram_wmask) | (mem[sram_addr] & ~sram_wmask);
            else         sram_rd <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic preload(input logic [8:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        step();
        load_en   = 1'b0;
    endtask

    // Called at a negedge while idle; returns at the negedge of the first busy cycle.
    task automatic issue(input logic [1:0] op, input logic [8:0] src, input logic [8:0] dst,
                         input logic [7:0] len);
        cmd_op  = op;
        cmd_src = src;
        cmd_dst = dst;
        cmd_len = len;
        cmd_v   = 1'b1;
        check("ready_before_accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_v   = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_v   = 1'b0;
        abort   = 1'b0;
        cmd_op  = '0;
        cmd_src = '0;
        cmd_dst = '0;
        cmd_len = '0;
        repeat (2) step();
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ce",    32'(sram_ce), 32'd0);
        check("rst_wmask", 32'(sram_wmask), 32'hFF);
        check("rst_elems", 32'(elems_done), 32'd0);
        reset_n = 1'b1;
        step();

        // single element add
        preload(9'd0, 8'd1);
        preload(9'd1, 8'd3);
        issue(2'b00, 9'd0, 9'd16, 8'd1);
        check("t1_c1_addr", 32'(sram_addr), 32'd0);
        check("t1_c1_ready", 32'(cmd_ready), 32'd0);
        step(); check("t1_c2_addr", 32'(sram_addr), 32'd1);
        step(); check("t1_c3_ce", 32'(sram_ce), 32'd0);
        step(); check("t1_c4_we", 32'(sram_we), 32'd1);
        check("t1_c4_addr", 32'(sram_addr), 32'd16);
        check("t1_c4_wd", 32'(sram_wd), 32'd4);
        step(); check("t1_done", 32'(done), 32'd1);
        check("t1_aborted", 32'(aborted), 32'd0);
        check("t1_elems", 32'(elems_done), 32'd1);
        check("t1_busy_done", 32'(busy), 32'd1);
        step(); check("t1_idle_done", 32'(done), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_mem16", 32'(mem[16]), 32'd4);

        // three element subtract, address sequence
        preload(9'd0, 8'd5); preload(9'd1, 8'd2); preload(9'd2, 8'd9);
        preload(9'd3, 8'd4); preload(9'd4, 8'd7); preload(9'd5, 8'd7);
        issue(2'b01, 9'd0, 9'd100, 8'd3);
        for (int c = 0; c < 12; c++) begin
            check("t2_ce", 32'(sram_ce), 32'((c % 4) != 2));
            check("t2_we", 32'(sram_we), 32'((c % 4) == 3));
            check("t2_addr", 32'(sram_addr), 32'(exp_addr2[c]));
            if ((c % 4) == 3) check("t2_wd", 32'(sram_wd), 32'(exp_wd2[c / 4]));
            step();
        end
        check("t2_done", 32'(done), 32'd1);
        check("t2_elems", 32'(elems_done), 32'd3);
        step();
        check("t2_mem100", 32'(mem[100]), 32'd3);
        check("t2_mem101", 32'(mem[101]), 32'd5);
        check("t2_mem102", 32'(mem[102]), 32'd0);

        // address wrap-around with OR
        preload(9'd510, 8'h0F); preload(9'd511, 8'h30);
        preload(9'd0, 8'h01);   preload(9'd1, 8'h80);
        issue(2'b11, 9'd510, 9'd511, 8'd2);
        for (int c = 0; c < 8; c++) begin
            check("t3_ce", 32'(sram_ce), 32'((c % 4) != 2));
            check("t3_addr", 32'(sram_addr), 32'(exp_addr3[c]));
            step();
        end
        check("t3_done", 32'(done), 32'd1);
        step();
        check("t3_mem511", 32'(mem[511]), 32'h3F);
        check("t3_mem0", 32'(mem[0]), 32'h81);

        // zero length
        issue(2'b00, 9'd7, 9'd8, 8'd0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_ce", 32'(sram_ce), 32'd0);
        check("t4_elems", 32'(elems_done), 32'd0);
        step();
        check("t4_ce_after", 32'(sram_ce), 32'd0);
        check("t4_ready", 32'(cmd_ready), 32'd1);

        // abort during element 1 read of B
        for (int i = 0; i < 10; i++) preload(9'(i), 8'(i + 1));
        preload(9'd202, 8'hAA);
        issue(2'b00, 9'd0, 9'd200, 8'd5);
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) check("t5_c8_addr", 32'(sram_addr), 32'd201);
            abort = (c == 6);
            step();
        end
        abort = 1'b0;
        check("t5_done", 32'(done), 32'd1);
        check("t5_aborted", 32'(aborted), 32'd1);
        check("t5_elems", 32'(elems_done), 32'd2);
        step();
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_mem200", 32'(mem[200]), 32'd3);
        check("t5_mem201", 32'(mem[201]), 32'd7);
        check("t5_mem202", 32'(mem[202]), 32'hAA);

        // cmd_v held through busy; second command waits for IDLE
        preload(9'd0, 8'hF0); preload(9'd1, 8'h3C);
        preload(9'd2, 8'h10); preload(9'd3, 8'h01);
        cmd_op = 2'b10; cmd_src = 9'd0; cmd_dst = 9'd300; cmd_len = 8'd1;
        cmd_v = 1'b1;
        step();
        cmd_op = 2'b01; cmd_src = 9'd2; cmd_dst = 9'd301; cmd_len = 8'd1;
        check("t6_c1_ready", 32'(cmd_ready), 32'd0);
        repeat (4) step();
        check("t6_c5_done", 32'(done), 32'd1);
        step();
        check("t6_c6_ready", 32'(cmd_ready), 32'd1);
        check("t6_c6_busy", 32'(busy), 32'd0);
        step();
        cmd_v = 1'b0;
        check("t6_c7_busy", 32'(busy), 32'd1);
        check("t6_c7_addr", 32'(sram_addr), 32'd2);
        repeat (3) step();
        check("t6_c10_addr", 32'(sram_addr), 32'd301);
        check("t6_c10_wd", 32'(sram_wd), 32'h0F);
        step();
        check("t6_c11_done", 32'(done), 32'd1);
        step();
        check("t6_mem300", 32'(mem[300]), 32'h30);
        check("t6_mem301", 32'(mem[301]), 32'h0F);

        // asynchronous reset during WR of element 2
        preload(9'd402, 8'h55);
        issue(2'b00, 9'd0, 9'd400, 8'd4);
        repeat (11) step();
        check("t7_we", 32'(sram_we), 32'd1);
        check("t7_addr", 32'(sram_addr), 32'd402);
        #1 reset_n = 1'b0;
        #1;
        check("t7_ce", 32'(sram_ce), 32'd0);
        check("t7_we_rst", 32'(sram_we), 32'd0);
        check("t7_addr_rst", 32'(sram_addr), 32'd0);
        check("t7_wd_rst", 32'(sram_wd), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_ready", 32'(cmd_ready), 32'd1);
        check("t7_elems", 32'(elems_done), 32'd0);
        check("t7_alu_a", 32'(alu_a), 32'd0);
        check("t7_alu_sel", 32'(alu_sel), 32'd0);
        step();
        check("t7_mem402", 32'(mem[402]), 32'h55);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("t7_no_done", 32'(done), 32'd0);
            check("t7_idle_ce", 32'(sram_ce), 32'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
